// File: rtl/fp32_mult_norm_seq.sv
// fp32_mult_norm_seq: multi-cycle significand multiply and normalize stage of the FP32 multiplier.
// A shift-add engine retires BITS_PER_CYCLE multiplier bits per MULT cycle into a 48-bit accumulator.
// The finished product is then normalized into registered NormM/NormE/Sp/GRS/InputExc outputs.
// Optional feature macro: FPMULT_ZERO_BYPASS_EN. When it is defined, an operand with a zero exponent
// skips MULT, and the stage presents a zero significand product two cycles after accept.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1.
// in_ready is high only in IDLE. out_valid is high only in HOLD, and every result output stays
// unchanged until the edge that sees out_ready=1. in_valid is ignored outside IDLE, and out_ready
// is ignored outside HOLD.
module fp32_mult_norm_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [22:0] NormM,
  output logic [8:0]  NormE,
  output logic        Sp,
  output logic        GRS,
  output logic [4:0]  InputExc,
  output logic [1:0]  dbg_state
);

  localparam int N  = 24 / BITS_PER_CYCLE;
  localparam int PW = 24 + BITS_PER_CYCLE;
  localparam logic [4:0] CNT_LAST = 5'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [22:0] norm_m_q, norm_m_d;
  logic [8:0]  norm_e_q, norm_e_d;
  logic        sp_q, sp_d;
  logic        grs_q, grs_d;
  logic [4:0]  exc_q, exc_d;
  logic [47:0] acc_q, acc_d;
  logic [23:0] ma_q, ma_d;
  logic [23:0] mb_q, mb_d;
  logic [8:0]  esum_q, esum_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [7:0]      ea, eb;
  logic            a_nan, a_inf, b_nan, b_inf;
  logic [PW-1:0]   part, psum;
  logic [PW+23:0]  wide;
  logic [47:0]     acc_shift;
  logic [22:0]     norm_m;
  logic [8:0]      norm_e;
  logic            g_bit, s_bit;

  assign ea    = a[30:23];
  assign eb    = b[30:23];
  assign a_nan = (&ea) & (|a[22:0]);
  assign a_inf = (&ea) & ~(|a[22:0]);
  assign b_nan = (&eb) & (|b[22:0]);
  assign b_inf = (&eb) & ~(|b[22:0]);

  // One shift-add step: add the low multiplier group times Ma into the upper half, then shift right.
  always_comb begin
    part      = PW'(mb_q[BITS_PER_CYCLE-1:0]) * PW'(ma_q);
    psum      = part + PW'(acc_q[47:24]);
    wide      = {psum, acc_q[23:0]};
    acc_shift = 48'(wide >> BITS_PER_CYCLE);
  end

  // Normalize the finished product: a product in [2,4) takes one extra exponent step.
  always_comb begin
    if (acc_q[47]) begin
      norm_m = acc_q[46:24];
      g_bit  = acc_q[23];
      s_bit  = |acc_q[22:0];
      norm_e = esum_q + 9'd1;
    end else begin
      norm_m = acc_q[45:23];
      g_bit  = acc_q[22];
      s_bit  = |acc_q[21:0];
      norm_e = esum_q;
    end
  end

  // Next-state and next-output logic for the IDLE -> MULT -> NORM -> HOLD sequence.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    norm_m_d    = norm_m_q;
    norm_e_d    = norm_e_q;
    sp_d        = sp_q;
    grs_d       = grs_q;
    exc_d       = exc_q;
    acc_d       = acc_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    esum_d      = esum_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          ma_d       = {|ea, a[22:0]};
          mb_d       = {|eb, b[22:0]};
          esum_d     = {1'b0, ea} + {1'b0, eb};
          sp_d       = a[31] ^ b[31];
          exc_d      = {a_inf | b_inf | a_nan | b_nan, a_nan, b_nan, a_inf, b_inf};
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = MULT;
`ifdef FPMULT_ZERO_BYPASS_EN
          if (ea == 8'd0 || eb == 8'd0) begin
            state_d = NORM;
          end
`endif
        end
      end
      MULT: begin
        acc_d = acc_shift;
        mb_d  = mb_q >> BITS_PER_CYCLE;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = NORM;
        end
      end
      NORM: begin
        norm_m_d    = norm_m;
        norm_e_d    = norm_e;
        grs_d       = g_bit & (norm_m[0] | s_bit);
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      norm_m_q    <= '0;
      norm_e_q    <= '0;
      sp_q        <= 1'b0;
      grs_q       <= 1'b0;
      exc_q       <= '0;
      acc_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      esum_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      norm_m_q    <= norm_m_d;
      norm_e_q    <= norm_e_d;
      sp_q        <= sp_d;
      grs_q       <= grs_d;
      exc_q       <= exc_d;
      acc_q       <= acc_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      esum_q      <= esum_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign NormM     = norm_m_q;
  assign NormE     = norm_e_q;
  assign Sp        = sp_q;
  assign GRS       = grs_q;
  assign InputExc  = exc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp32_mult_norm_seq.sv
// Testbench for fp32_mult_norm_seq: directed cases, reset cases and random operand pairs,
// all checked against a behavioural model of the significand product and its normalization.
module tb_fp32_mult_norm_seq;

  localparam int BPC = 1;
  localparam int N   = 24 / BPC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, Sp, GRS;
  logic [22:0] NormM;
  logic [8:0]  NormE;
  logic [4:0]  InputExc;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_mode = 1;  // 0: random out_ready, 1: always ready, 2: held low

  // Expected result word: {NormM, NormE, Sp, GRS, InputExc}.
  logic [38:0] exp_q[$];
  int          lat_q[$];

  fp32_mult_norm_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .NormM(NormM), .NormE(NormE), .Sp(Sp), .GRS(GRS), .InputExc(InputExc),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [38:0] model(input logic [31:0] x, input logic [31:0] y);
    longint unsigned ex, ey, mx, my, p, nm, ne, g, s;
    logic sp, grs;
    logic x_inf, x_nan, y_inf, y_nan;
    ex = longint'(x[30:23]);
    ey = longint'(y[30:23]);
    mx = (ex != 0 ? 64'h80_0000 : 64'h0) + longint'(x[22:0]);
    my = (ey != 0 ? 64'h80_0000 : 64'h0) + longint'(y[22:0]);
    p  = mx * my;
`ifdef FPMULT_ZERO_BYPASS_EN
    if (ex == 0 || ey == 0) p = 0;
`endif
    if (p >= 64'h8000_0000_0000) begin
      nm = (p >> 24) & 64'h7F_FFFF;
      g  = (p >> 23) & 64'h1;
      s  = ((p & 64'h7F_FFFF) != 0) ? 1 : 0;
      ne = (ex + ey + 1) % 512;
    end else begin
      nm = (p >> 23) & 64'h7F_FFFF;
      g  = (p >> 22) & 64'h1;
      s  = ((p & 64'h3F_FFFF) != 0) ? 1 : 0;
      ne = (ex + ey) % 512;
    end
    grs   = (g == 1) && ((nm % 2) == 1 || s == 1);
    sp    = x[31] ^ y[31];
    x_inf = (ex == 255) && (x[22:0] == 0);
    x_nan = (ex == 255) && (x[22:0] != 0);
    y_inf = (ey == 255) && (y[22:0] == 0);
    y_nan = (ey == 255) && (y[22:0] != 0);
    return {nm[22:0], ne[8:0], sp, grs, (x_inf | y_inf | x_nan | y_nan), x_nan, y_nan, x_inf, y_inf};
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge; returns at a negedge after the pair has been accepted.
  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int w;
    int lat;
    w   = 0;
    lat = N + 2;
`ifdef FPMULT_ZERO_BYPASS_EN
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) lat = 2;
`endif
    in_valid = 1'b1;
    a = x;
    b = y;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      exp_q.push_back(model(x, y));
      lat_q.push_back(cyc + 1 + lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_NormM"}, 64'(NormM), 64'd0);
    chk({tag, "_NormE"}, 64'(NormE), 64'd0);
    chk({tag, "_Sp"}, 64'(Sp), 64'd0);
    chk({tag, "_GRS"}, 64'(GRS), 64'd0);
    chk({tag, "_InputExc"}, 64'(InputExc), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:0] = '0;
      1: v[30:23] = 8'hFF;
      2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      3: v[30:23] = 8'h00;
      4: v[22:0] = 23'h7F_FFFF;
      default: ;
    endcase
    return v;
  endfunction

  // out_ready changes just after each rising edge so the monitor sees it settled at the negedge.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard / compare process ----------------
  logic [38:0] e;
  logic        seen_valid = 1'b0;
  logic        prev_hs = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_hs) chk("out_valid_drop", 64'(out_valid), 64'd0);
      prev_hs = 1'b0;
      if (out_valid) begin
        chk("in_ready_in_hold", 64'(in_ready), 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q[0];
          if (!seen_valid) begin
            chk("latency_edge", 64'(cyc + 1), 64'(lat_q[0]));
            seen_valid = 1'b1;
          end
          chk("NormM", 64'(NormM), 64'(e[38:16]));
          chk("NormE", 64'(NormE), 64'(e[15:7]));
          chk("Sp", 64'(Sp), 64'(e[6]));
          chk("GRS", 64'(GRS), 64'(e[5]));
          chk("InputExc", 64'(InputExc), 64'(e[4:0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            seen_valid = 1'b0;
            prev_hs    = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int ov_seen;

    // Hand-computed values pin the model.
    chk("pin_t1", 64'(model(32'h3F80_0000, 32'h3F80_0000)), 64'({23'h0, 9'd254, 1'b0, 1'b0, 5'b00000}));
    chk("pin_t2", 64'(model(32'h3FC0_0000, 32'h3FC0_0000)), 64'({23'h10_0000, 9'd255, 1'b0, 1'b0, 5'b00000}));
    chk("pin_t3", 64'(model(32'hC000_0000, 32'h4040_0000)), 64'({23'h40_0000, 9'd256, 1'b1, 1'b0, 5'b00000}));
    chk("pin_t4", 64'(model(32'h3FC0_0000, 32'h3F80_0001)), 64'({23'h40_0001, 9'd254, 1'b0, 1'b1, 5'b00000}));
    chk("pin_t5", 64'(model(32'h7F80_0000, 32'h3F80_0000)), 64'({23'h0, 9'd382, 1'b0, 1'b0, 5'b10010}));

    // Reset state, then in_ready rises on the first edge after release.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    #2 rst_n = 1'b1;
    #1 chk("in_ready_after_release", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("in_ready_first_clk", 64'(in_ready), 64'd1);

    // Directed cases 1-4 back to back.
    rdy_mode = 1;
    send(32'h3F80_0000, 32'h3F80_0000);
    send(32'h3FC0_0000, 32'h3FC0_0000);
    send(32'hC000_0000, 32'h4040_0000);
    send(32'h3FC0_0000, 32'h3F80_0001);
    drain();

    // Case 5: held result with out_ready low; a new pair waits for the handshake.
    rdy_mode = 2;
    send(32'h7F80_0000, 32'h3F80_0000);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("t5_out_valid_seen", 64'(out_valid), 64'd1);
    fork
      begin
        repeat (5) @(negedge clk);
        rdy_mode = 1;
      end
      send(32'h3FC0_0000, 32'h3FC0_0000);
    join
    drain();

`ifdef FPMULT_ZERO_BYPASS_EN
    chk("pin_bypass", 64'(model(32'h0000_0000, 32'h3F80_0000)), 64'({23'h0, 9'd127, 1'b0, 1'b0, 5'b00000}));
    send(32'h0000_0000, 32'h3F80_0000);
    drain();
`endif

    // Case 6: reset in the middle of MULT clears everything and no result appears.
    send(32'h4049_0FDB, 32'h3F35_04F3);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("mid_in_ready_after_release", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("mid_in_ready_first_clk", 64'(in_ready), 64'd1);
    ov_seen = 0;
    repeat (N + 10) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("no_partial_result", 64'(ov_seen), 64'd0);

    // Random operands with random gaps and random out_ready back-pressure.
    rdy_mode = 0;
    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rnd_op(), rnd_op());
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
